lamp_conflict_monitor: RTL and testbench
========================================

Name: lamp_conflict_monitor

Overview:
Safety stage directly downstream of the two-approach traffic-light controller. Consumes its six lamp outputs: GRN1/YLW1/RED1 for approach 1 and GRN2/YLW2/RED2 for approach 2. Passes them to the lamp drivers only while the sequence is legal. On any violation it latches a fault code, forces both approaches to flashing red, and holds there until acknowledged.

Parameters:
YLW_MIN, 2, minimum consecutive cycles a yellow must be held before red (1..15).
FLASH_DIV, 4, half-period in cycles of fault red flashing (1..255).
SYNC_CNT, 2, consecutive clean input cycles required in SYNC before PASS (1..15).

Ports:
CK  input  1  clock; all state changes on rising edge.
CLRN  input  1  reset; asynchronous, active-low.
GRN1_I, YLW1_I, RED1_I  input  1 each  approach-1 lamps from controller.
GRN2_I, YLW2_I, RED2_I  input  1 each  approach-2 lamps from controller.
ACK  input  1  fault acknowledge; level, sampled per cycle.
GRN1, YLW1, RED1, GRN2, YLW2, RED2  output  1 each  registered lamp drives.
FAULT  output  1  high while in FLASH.
FCODE  output  3  latched violation code; 0 = none.

Behaviour:
- Reset is asynchronous and active-low: CLRN=0 immediately forces the values below, regardless of CK.
  - state=SYNC; S1/S2 sample registers cleared; yellow counters=0.
  - RED1=RED2=1; all other lamp outputs 0; FAULT=0; FCODE=0.
- Pipeline:
  - S1 <= inputs every cycle; S2 <= S1.
  - Checks are combinational on S1, plus S2 for transitions.
  - Output registers load from S1, so input-to-output latency is 2 edges.
  - A violating S1 pattern never reaches the outputs.
- Checks, per approach a:
  - code 1: S1 lamps not one-hot.
  - code 2: RED1=0 and RED2=0 in S1 (conflict).
  - code 3: S2=G and S1=R (yellow skipped).
  - code 4: S2=R and S1=Y, or S2=Y and S1=G (reverse order).
  - code 5: S2=Y, S1=R, and ycnt_a < YLW_MIN.
  - Several codes true at once: the lowest code is latched.
- Yellow counter ycnt_a (4 bits, saturating at 15):
  - S1=Y: S2!=Y -> 1; else increment.
  - S1!=Y: -> 0.
  - Counts only in PASS; held at 0 in SYNC and FLASH.
- State SYNC:
  - Outputs RED1=RED2=1, others 0.
  - Transition checks (codes 3-5) are ignored; codes 1 and 2 only reset the clean counter.
  - After SYNC_CNT consecutive clean S1 cycles -> PASS.
  - The lamp outputs load S1 on the same edge as the transition.
- State PASS:
  - No violation: outputs <= S1.
  - Violation: -> FLASH.
    - FCODE <= code; FAULT <= 1.
    - Flash divider reset, phase=on; RED1=RED2=1, others 0.
- State FLASH:
  - GRN/YLW outputs=0.
  - RED1=RED2=phase; phase toggles every FLASH_DIV cycles.
  - Inputs are still sampled, but checks do not update FCODE.
  - ACK=1 and S1 shows RED1=RED2=1, one-hot per approach, on that edge:
    - -> SYNC; FAULT <= 0; FCODE <= 0.
    - Outputs solid red; the clean counter restarts.
  - ACK=1 with any other S1 pattern: ignored, stay in FLASH.
- ACK in SYNC or PASS is ignored.
- Reset asserted mid-FLASH or mid-PASS returns to the reset values; FCODE is lost.

Optional Feature:
Macro MON_FLTCNT_EN.
- Defined:
  - Adds output FCNT, 8 bits.
  - Increments on each PASS->FLASH entry; saturates at 255.
  - Cleared only by CLRN=0.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release; inputs R/R, then approach 1 G with approach 2 R; defaults YLW_MIN=2, SYNC_CNT=2 -> solid red for the sync window, PASS after 2 clean cycles, GRN1=1 appears 2 edges after the input, FAULT=0.
- In PASS, legal cycle G1 (5 cyc) -> Y1 (2 cyc) -> R1, with approach 2 R -> G -> Y -> R -> outputs mirror the inputs at 2-cycle latency, FCODE stays 0.
- In PASS, GRN1_I and GRN2_I both 1, RED1_I=RED2_I=0, for one cycle -> outputs never show the double green; FAULT=1, FCODE=2; RED1/RED2 toggle every 4 cycles.
- Y1 held 1 cycle then R1 -> FCODE=5. Repeat with G1 directly to R1 -> FCODE=3. Repeat with G1 and Y1 both set -> FCODE=1.
- In FLASH, ACK=1 with inputs G1/R2 -> stays in FLASH. ACK=1 with inputs R/R -> FAULT=0, FCODE=0, solid red, PASS 2 cycles later.
- CLRN pulsed low between clock edges while in FLASH -> outputs immediately RED1=RED2=1, FCODE=0; with MON_FLTCNT_EN, FCNT=0 after reset and 1 after the next fault.

Source files
------------

// File: rtl/lamp_conflict_monitor.sv
// ============================================================================
// lamp_conflict_monitor
//
// Safety stage placed directly after a two-approach traffic-light controller.
// It samples the six lamp requests and forwards them to the lamp drivers only
// while the lamp sequence is legal. On a violation it latches a fault code and
// forces both approaches to flashing red. It stays there until the fault is
// acknowledged while the controller is showing all-red.
//
// Pipeline: inputs -> S1 -> S2. The legality checks look at S1, and at S2 for
// transitions. The output registers load from S1, so a lamp request reaches
// the drivers two clock edges after it is applied. A violating S1 pattern is
// caught on the same edge that would have loaded it, so it never reaches the
// drivers.
//
// Fault codes (the lowest code wins when several hold at once):
//   1  an approach is not one-hot in S1
//   2  neither approach shows red in S1 (conflict)
//   3  green went straight to red (yellow skipped)
//   4  red->yellow or yellow->green (reverse order)
//   5  yellow->red after fewer than YLW_MIN yellow cycles
//
// Parameters:
//   YLW_MIN    minimum yellow hold in cycles before red (1..15)
//   FLASH_DIV  half-period of the fault flashing in cycles (1..255)
//   SYNC_CNT   clean S1 cycles needed in SYNC before passing (1..15)
//
// Ports:
//   CK                  clock, rising edge
//   CLRN                asynchronous active-low reset
//   GRN1_I/YLW1_I/RED1_I  approach-1 lamp requests from the controller
//   GRN2_I/YLW2_I/RED2_I  approach-2 lamp requests from the controller
//   ACK                 fault acknowledge (level)
//   GRN1..RED2          registered lamp drives
//   FAULT               high while flashing on a fault
//   FCODE               latched fault code, 0 = none
//   FCNT                (only with MON_FLTCNT_EN) saturating count of fault
//                       entries, cleared only by reset
//
// Build option: define MON_FLTCNT_EN to add the FCNT fault counter.
// ============================================================================
module lamp_conflict_monitor #(
    parameter int unsigned YLW_MIN   = 2,
    parameter int unsigned FLASH_DIV = 4,
    parameter int unsigned SYNC_CNT  = 2
) (
    input  logic       CK,
    input  logic       CLRN,
    input  logic       GRN1_I,
    input  logic       YLW1_I,
    input  logic       RED1_I,
    input  logic       GRN2_I,
    input  logic       YLW2_I,
    input  logic       RED2_I,
    input  logic       ACK,
    output logic       GRN1,
    output logic       YLW1,
    output logic       RED1,
    output logic       GRN2,
    output logic       YLW2,
    output logic       RED2,
    output logic       FAULT,
    output logic [2:0] FCODE
`ifdef MON_FLTCNT_EN
    ,
    output logic [7:0] FCNT
`endif
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FLASH = 2'd2
    } state_e;

    // Per-approach lamp patterns packed as {green, yellow, red}.
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    localparam logic [3:0] YLW_MIN_L    = 4'(YLW_MIN);
    localparam logic [3:0] SYNC_CNT_L   = 4'(SYNC_CNT);
    localparam logic [7:0] FLASH_DIV_M1 = 8'(FLASH_DIV - 1);

    // Index 0 is approach 1, index 1 is approach 2.
    logic [1:0][2:0] lamps_in;

    state_e          state_q, state_d;
    logic [1:0][2:0] s1_q, s1_d;
    logic [1:0][2:0] s2_q, s2_d;
    logic [1:0][3:0] ycnt_q, ycnt_d;
    logic [3:0]      clean_q, clean_d;
    logic [1:0][2:0] out_q, out_d;
    logic            fault_q, fault_d;
    logic [2:0]      fcode_q, fcode_d;
    logic [7:0]      flash_div_q, flash_div_d;
    logic            phase_q, phase_d;

    logic [2:0]      tcode1;
    logic [2:0]      tcode2;
    logic            onehot_ok;
    logic            conflict;
    logic            basic_bad;
    logic            all_red;
    logic [2:0]      vcode;
    logic [3:0]      clean_inc;

    assign lamps_in[0] = {GRN1_I, YLW1_I, RED1_I};
    assign lamps_in[1] = {GRN2_I, YLW2_I, RED2_I};

    function automatic logic is_one_hot(input logic [2:0] lamp);
        return (lamp == LAMP_G) || (lamp == LAMP_Y) || (lamp == LAMP_R);
    endfunction

    // Transition fault for one approach. The branches are tested in
    // ascending code order, so the lowest code applies.
    function automatic logic [2:0] trans_code(input logic [2:0] prev,
                                              input logic [2:0] cur,
                                              input logic [3:0] ycnt);
        logic [2:0] code;
        code = 3'd0;
        if (prev == LAMP_G && cur == LAMP_R) begin
            code = 3'd3;
        end else if ((prev == LAMP_R && cur == LAMP_Y) ||
                     (prev == LAMP_Y && cur == LAMP_G)) begin
            code = 3'd4;
        end else if (prev == LAMP_Y && cur == LAMP_R && ycnt < YLW_MIN_L) begin
            code = 3'd5;
        end
        return code;
    endfunction

    // Violation detection on the S1/S2 pair. Codes 1 and 2 depend only on
    // S1. They are also the only checks that matter while synchronising.
    always_comb begin
        tcode1    = trans_code(s2_q[0], s1_q[0], ycnt_q[0]);
        tcode2    = trans_code(s2_q[1], s1_q[1], ycnt_q[1]);
        onehot_ok = is_one_hot(s1_q[0]) && is_one_hot(s1_q[1]);
        conflict  = !s1_q[0][0] && !s1_q[1][0];
        vcode     = 3'd0;
        if (!onehot_ok) begin
            vcode = 3'd1;
        end else if (conflict) begin
            vcode = 3'd2;
        end else if (tcode1 != 3'd0 && (tcode2 == 3'd0 || tcode1 <= tcode2)) begin
            vcode = tcode1;
        end else begin
            vcode = tcode2;
        end
    end

    assign basic_bad = !onehot_ok || conflict;
    assign all_red   = (s1_q[0] == LAMP_R) && (s1_q[1] == LAMP_R);
    assign clean_inc = clean_q + 4'd1;

    // Yellow run length per approach. It restarts at 1 on the first yellow
    // sample and saturates at 15. It only runs while passing, so a yellow
    // that began before PASS is counted from the PASS entry onward.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            ycnt_d[a] = 4'd0;
            if (state_q == ST_PASS && s1_q[a] == LAMP_Y) begin
                if (s2_q[a] != LAMP_Y) begin
                    ycnt_d[a] = 4'd1;
                end else if (ycnt_q[a] != 4'hF) begin
                    ycnt_d[a] = ycnt_q[a] + 4'd1;
                end else begin
                    ycnt_d[a] = 4'hF;
                end
            end
        end
    end

    // Main monitor FSM. Both sample stages shift every cycle in every state.
    // The outputs, fault status and flash timing depend on the state.
    always_comb begin
        state_d     = state_q;
        s1_d        = lamps_in;
        s2_d        = s1_q;
        clean_d     = clean_q;
        out_d       = out_q;
        fault_d     = fault_q;
        fcode_d     = fcode_q;
        flash_div_d = flash_div_q;
        phase_d     = phase_q;

        case (state_q)
            ST_SYNC: begin
                out_d = {LAMP_R, LAMP_R};
                if (basic_bad) begin
                    clean_d = 4'd0;
                end else if (clean_inc >= SYNC_CNT_L) begin
                    // The S1 that completes the clean window goes straight
                    // to the drivers on this same edge.
                    state_d = ST_PASS;
                    clean_d = 4'd0;
                    out_d   = s1_q;
                end else begin
                    clean_d = clean_inc;
                end
            end

            ST_PASS: begin
                if (vcode != 3'd0) begin
                    state_d     = ST_FLASH;
                    fault_d     = 1'b1;
                    fcode_d     = vcode;
                    flash_div_d = 8'd0;
                    phase_d     = 1'b1;
                    out_d       = {LAMP_R, LAMP_R};
                end else begin
                    out_d = s1_q;
                end
            end

            ST_FLASH: begin
                if (ACK && all_red) begin
                    // The acknowledge only counts while the controller
                    // itself is showing all-red.
                    state_d     = ST_SYNC;
                    fault_d     = 1'b0;
                    fcode_d     = 3'd0;
                    clean_d     = 4'd0;
                    flash_div_d = 8'd0;
                    phase_d     = 1'b1;
                    out_d       = {LAMP_R, LAMP_R};
                end else begin
                    if (flash_div_q == FLASH_DIV_M1) begin
                        flash_div_d = 8'd0;
                        phase_d     = !phase_q;
                    end else begin
                        flash_div_d = flash_div_q + 8'd1;
                    end
                    out_d[0] = {2'b00, phase_d};
                    out_d[1] = {2'b00, phase_d};
                end
            end

            default: begin
                state_d = ST_SYNC;
                out_d   = {LAMP_R, LAMP_R};
            end
        endcase
    end

    // State and pipeline registers. Reset gives solid red with no fault.
    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            state_q     <= ST_SYNC;
            s1_q        <= '0;
            s2_q        <= '0;
            ycnt_q      <= '0;
            clean_q     <= 4'd0;
            out_q       <= {LAMP_R, LAMP_R};
            fault_q     <= 1'b0;
            fcode_q     <= 3'd0;
            flash_div_q <= 8'd0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            ycnt_q      <= ycnt_d;
            clean_q     <= clean_d;
            out_q       <= out_d;
            fault_q     <= fault_d;
            fcode_q     <= fcode_d;
            flash_div_q <= flash_div_d;
            phase_q     <= phase_d;
        end
    end

`ifdef MON_FLTCNT_EN
    // Fault-entry counter. It counts each PASS->FLASH entry, saturates at
    // 255 and is cleared only by reset, so it survives acknowledges.
    logic [7:0] fcnt_q, fcnt_d;
    logic       flash_entry;

    assign flash_entry = (state_q == ST_PASS) && (vcode != 3'd0);

    always_comb begin
        fcnt_d = fcnt_q;
        if (flash_entry && fcnt_q != 8'hFF) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            fcnt_q <= 8'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign FCNT = fcnt_q;
`else
    // Without the fault counter, fault entries are only visible on FAULT
    // and FCODE.
`endif

    assign GRN1  = out_q[0][2];
    assign YLW1  = out_q[0][1];
    assign RED1  = out_q[0][0];
    assign GRN2  = out_q[1][2];
    assign YLW2  = out_q[1][1];
    assign RED2  = out_q[1][0];
    assign FAULT = fault_q;
    assign FCODE = fcode_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Testbench for lamp_conflict_monitor. A reference model derived from the
// lamp rules predicts the outputs for every cycle. Directed sequences pin
// fault codes, latency and flashing with literal values. Randomised
// controller-like traffic with injected glitches and random acknowledges
// then exercises the rest.
module tb_lamp_conflict_monitor;

    localparam int YLW_MIN   = 2;
    localparam int FLASH_DIV = 4;
    localparam int SYNC_CNT  = 2;

    // Lamp vectors packed {G1,Y1,R1,G2,Y2,R2}.
    localparam logic [5:0] V_RR  = 6'b001_001;
    localparam logic [5:0] V_GR  = 6'b100_001;
    localparam logic [5:0] V_YR  = 6'b010_001;
    localparam logic [5:0] V_RG  = 6'b001_100;
    localparam logic [5:0] V_RY  = 6'b001_010;
    localparam logic [5:0] V_GG  = 6'b100_100;
    localparam logic [5:0] V_GYR = 6'b110_001;
    localparam logic [5:0] V_OFF = 6'b000_000;

    localparam logic [2:0] L_G = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_R = 3'b001;

    localparam int M_SYNC  = 0;
    localparam int M_PASS  = 1;
    localparam int M_FLASH = 2;

    logic       CK = 1'b0;
    logic       CLRN;
    logic [5:0] in_vec;
    logic       ack;
    logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2, FAULT;
    logic [2:0] FCODE;
`ifdef MON_FLTCNT_EN
    logic [7:0] FCNT;
`endif
    logic [5:0] dut_lamps;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         m_mode;
    logic [5:0] m_s1, m_s2;
    int         m_y[2];
    int         m_ny[2];
    int         m_clean;
    int         m_age;
    int         m_code;
    logic [5:0] exp_lamps;
    logic       exp_fault;
    logic [2:0] exp_fcode;
    int         exp_fcnt;

    int         phase_idx;
    int         remain;
    logic [5:0] rnd_vec;

    always #5 CK = ~CK;

    lamp_conflict_monitor #(
        .YLW_MIN  (YLW_MIN),
        .FLASH_DIV(FLASH_DIV),
        .SYNC_CNT (SYNC_CNT)
    ) dut (
        .CK    (CK),
        .CLRN  (CLRN),
        .GRN1_I(in_vec[5]),
        .YLW1_I(in_vec[4]),
        .RED1_I(in_vec[3]),
        .GRN2_I(in_vec[2]),
        .YLW2_I(in_vec[1]),
        .RED2_I(in_vec[0]),
        .ACK   (ack),
        .GRN1  (GRN1),
        .YLW1  (YLW1),
        .RED1  (RED1),
        .GRN2  (GRN2),
        .YLW2  (YLW2),
        .RED2  (RED2),
        .FAULT (FAULT),
        .FCODE (FCODE)
`ifdef MON_FLTCNT_EN
        ,
        .FCNT  (FCNT)
`endif
    );

    assign dut_lamps = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};

    function automatic logic [2:0] lamp_of(input logic [5:0] v, input int a);
        return (a == 0) ? v[5:3] : v[2:0];
    endfunction

    // Every rule that fires is collected, and the smallest code is reported.
    function automatic int model_code(input logic [5:0] cur, input logic [5:0] prev,
                                      input int y0, input int y1);
        int         found[$];
        logic [2:0] l;
        logic [2:0] p;
        int         y;
        for (int a = 0; a < 2; a++) begin
            l = lamp_of(cur, a);
            p = lamp_of(prev, a);
            y = (a == 0) ? y0 : y1;
            if ($countones(l) != 1) found.push_back(1);
            if (p == L_G && l == L_R) found.push_back(3);
            if ((p == L_R && l == L_Y) || (p == L_Y && l == L_G)) found.push_back(4);
            if (p == L_Y && l == L_R && y < YLW_MIN) found.push_back(5);
        end
        if (!cur[3] && !cur[0]) found.push_back(2);
        if (found.size() == 0) return 0;
        found.sort();
        return found[0];
    endfunction

    // Reference model, advanced on each clock edge and on asynchronous reset.
    initial forever begin
        @(posedge CK or negedge CLRN);
        if (!CLRN) begin
            m_mode    = M_SYNC;
            m_s1      = '0;
            m_s2      = '0;
            m_y[0]    = 0;
            m_y[1]    = 0;
            m_clean   = 0;
            m_age     = 0;
            exp_lamps = V_RR;
            exp_fault = 1'b0;
            exp_fcode = 3'd0;
            exp_fcnt  = 0;
        end else begin
            m_code = model_code(m_s1, m_s2, m_y[0], m_y[1]);
            for (int a = 0; a < 2; a++) begin
                m_ny[a] = 0;
                if (m_mode == M_PASS && lamp_of(m_s1, a) == L_Y) begin
                    if (lamp_of(m_s2, a) == L_Y) m_ny[a] = (m_y[a] < 15) ? m_y[a] + 1 : 15;
                    else m_ny[a] = 1;
                end
            end
            if (m_mode == M_SYNC) begin
                if (m_code == 1 || m_code == 2) m_clean = 0;
                else m_clean++;
                if (m_clean >= SYNC_CNT) begin
                    m_mode    = M_PASS;
                    m_clean   = 0;
                    exp_lamps = m_s1;
                end else begin
                    exp_lamps = V_RR;
                end
            end else if (m_mode == M_PASS) begin
                if (m_code != 0) begin
                    m_mode    = M_FLASH;
                    exp_fault = 1'b1;
                    exp_fcode = 3'(m_code);
                    m_age     = 0;
                    exp_lamps = V_RR;
                    if (exp_fcnt < 255) exp_fcnt++;
                end else begin
                    exp_lamps = m_s1;
                end
            end else begin
                if (ack && m_s1 == V_RR) begin
                    m_mode    = M_SYNC;
                    exp_fault = 1'b0;
                    exp_fcode = 3'd0;
                    m_clean   = 0;
                    exp_lamps = V_RR;
                end else begin
                    m_age++;
                    exp_lamps = (((m_age / FLASH_DIV) % 2) == 0) ? V_RR : V_OFF;
                end
            end
            m_y[0] = m_ny[0];
            m_y[1] = m_ny[1];
            m_s2   = m_s1;
            m_s1   = in_vec;
        end
    end

    task automatic checkOutput();
        checks++;
        if ({dut_lamps, FAULT, FCODE} !== {exp_lamps, exp_fault, exp_fcode}) begin
            errors++;
            $display("[TB] FAIL cycle_compare t=%0t got lamps=%b fault=%b fcode=%0d want lamps=%b fault=%b fcode=%0d",
                     $time, dut_lamps, FAULT, FCODE, exp_lamps, exp_fault, exp_fcode);
        end
`ifdef MON_FLTCNT_EN
        checks++;
        if (FCNT !== 8'(exp_fcnt)) begin
            errors++;
            $display("[TB] FAIL fcnt_compare t=%0t got %0d want %0d", $time, FCNT, exp_fcnt);
        end
`endif
    endtask

    task automatic checkLit(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got %0h want %0h", name, $time, actual, expected);
        end
    endtask

    // Drives one input pattern immediately (called at a falling edge) and
    // holds it for the given number of rising edges. It returns at a falling
    // edge.
    task automatic applyStimulus(input logic [5:0] v, input logic a, input int cycles);
        in_vec = v;
        ack    = a;
        repeat (cycles) @(negedge CK);
    endtask

    task automatic recoverToPass();
        applyStimulus(V_RR, 1'b1, 1);
        applyStimulus(V_RR, 1'b0, 3);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge CK);
        if (CLRN === 1'b1) checkOutput();
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        in_vec = V_RR;
        ack    = 1'b0;
        CLRN   = 1'b1;
        #1 CLRN = 1'b0;
        #11;
        checkLit("reset_lamps", 32'(dut_lamps), 32'(V_RR));
        checkLit("reset_fault", 32'(FAULT), 32'd0);
        checkLit("reset_fcode", 32'(FCODE), 32'd0);
        CLRN = 1'b1;
        @(negedge CK);

        // Sync window, then GRN1 appears two edges after the input.
        applyStimulus(V_RR, 1'b0, 3);
        applyStimulus(V_GR, 1'b0, 1);
        checkLit("grn1_after_1_edge", 32'(GRN1), 32'd0);
        applyStimulus(V_GR, 1'b0, 1);
        checkLit("grn1_after_2_edges", 32'(GRN1), 32'd1);
        checkLit("pass_fault", 32'(FAULT), 32'd0);

        // A legal cycle on both approaches.
        applyStimulus(V_GR, 1'b0, 3);
        applyStimulus(V_YR, 1'b0, 2);
        checkLit("legal_yellow", 32'(dut_lamps), 32'(V_YR));
        applyStimulus(V_RR, 1'b0, 2);
        applyStimulus(V_RG, 1'b0, 5);
        applyStimulus(V_RY, 1'b0, 2);
        applyStimulus(V_RR, 1'b0, 3);
        checkLit("legal_fcode", 32'(FCODE), 32'd0);
        checkLit("legal_lamps", 32'(dut_lamps), 32'(V_RR));

        // Double green for one cycle.
        applyStimulus(V_GG, 1'b0, 1);
        applyStimulus(V_RR, 1'b0, 1);
        checkLit("conflict_fault", 32'(FAULT), 32'd1);
        checkLit("conflict_fcode", 32'(FCODE), 32'd2);
        checkLit("model_fcode2", 32'(exp_fcode), 32'd2);
        checkLit("flash_entry_red", 32'(dut_lamps), 32'(V_RR));
        applyStimulus(V_RR, 1'b0, 3);
        checkLit("flash_red_age3", 32'(dut_lamps), 32'(V_RR));
        applyStimulus(V_RR, 1'b0, 1);
        checkLit("flash_dark_age4", 32'(dut_lamps), 32'(V_OFF));
        applyStimulus(V_RR, 1'b0, 4);
        checkLit("flash_red_age8", 32'(dut_lamps), 32'(V_RR));

        // ACK with a non-red pattern is ignored; with all-red it exits.
        applyStimulus(V_GR, 1'b0, 1);
        applyStimulus(V_GR, 1'b1, 2);
        checkLit("ack_ignored_fault", 32'(FAULT), 32'd1);
        applyStimulus(V_RR, 1'b1, 1);
        checkLit("ack_ignored_stale", 32'(FAULT), 32'd1);
        applyStimulus(V_RR, 1'b1, 1);
        checkLit("ack_exit_fault", 32'(FAULT), 32'd0);
        checkLit("ack_exit_fcode", 32'(FCODE), 32'd0);
        checkLit("ack_exit_lamps", 32'(dut_lamps), 32'(V_RR));
        applyStimulus(V_GR, 1'b0, 1);
        checkLit("resync_red", 32'(dut_lamps), 32'(V_RR));
        applyStimulus(V_GR, 1'b0, 1);
        checkLit("resync_pass", 32'(dut_lamps), 32'(V_GR));

        // Short yellow.
        applyStimulus(V_GR, 1'b0, 3);
        applyStimulus(V_YR, 1'b0, 1);
        applyStimulus(V_RR, 1'b0, 2);
        checkLit("short_yellow_fcode", 32'(FCODE), 32'd5);
        recoverToPass();

        // Green straight to red.
        applyStimulus(V_GR, 1'b0, 3);
        applyStimulus(V_RR, 1'b0, 2);
        checkLit("skip_yellow_fcode", 32'(FCODE), 32'd3);
        recoverToPass();

        // Two lamps on one approach.
        applyStimulus(V_GR, 1'b0, 2);
        applyStimulus(V_GYR, 1'b0, 1);
        applyStimulus(V_RR, 1'b0, 1);
        checkLit("not_onehot_fcode", 32'(FCODE), 32'd1);
        recoverToPass();

        // Reset pulse between edges while flashing.
        applyStimulus(V_GG, 1'b0, 1);
        applyStimulus(V_RR, 1'b0, 1);
        checkLit("pre_reset_fcode", 32'(FCODE), 32'd2);
`ifdef MON_FLTCNT_EN
        checkLit("pre_reset_fcnt", 32'(FCNT), 32'd5);
`endif
        #2 CLRN = 1'b0;
        #1;
        checkLit("async_reset_lamps", 32'(dut_lamps), 32'(V_RR));
        checkLit("async_reset_fcode", 32'(FCODE), 32'd0);
        checkLit("async_reset_fault", 32'(FAULT), 32'd0);
`ifdef MON_FLTCNT_EN
        checkLit("async_reset_fcnt", 32'(FCNT), 32'd0);
`endif
        #1 CLRN = 1'b1;
        @(negedge CK);
        applyStimulus(V_RR, 1'b0, 3);
        applyStimulus(V_GG, 1'b0, 1);
        applyStimulus(V_RR, 1'b0, 1);
        checkLit("post_reset_fcode", 32'(FCODE), 32'd2);
`ifdef MON_FLTCNT_EN
        checkLit("post_reset_fcnt", 32'(FCNT), 32'd1);
`endif
        recoverToPass();

        // Randomised controller-like traffic with glitches and acknowledges.
        phase_idx = 0;
        remain    = 0;
        for (int c = 0; c < 3000; c++) begin
            if (remain == 0) begin
                phase_idx = (phase_idx + 1) % 6;
                case (phase_idx)
                    0, 3:    remain = int'($urandom_range(1, 3));
                    1, 4:    remain = int'($urandom_range(1, 6));
                    default: remain = int'($urandom_range(1, 4));
                endcase
            end
            case (phase_idx)
                1:       rnd_vec = V_GR;
                2:       rnd_vec = V_YR;
                4:       rnd_vec = V_RG;
                5:       rnd_vec = V_RY;
                default: rnd_vec = V_RR;
            endcase
            remain--;
            if ($urandom_range(0, 39) == 0) rnd_vec = 6'($urandom);
            applyStimulus(rnd_vec, ($urandom_range(0, 3) == 0), 1);
            if (c == 1500) begin
                #2 CLRN = 1'b0;
                #1 CLRN = 1'b1;
                @(negedge CK);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
